// File: rtl/game_board_engine.sv
// N x N two-player board engine: turn control, sequential K-in-a-row check,
// tie detection, one-level undo, restart and 2-digit BCD scores for the VGA painter.
module game_board_engine #(
  parameter int BOARD_N         = 3,
  parameter int WIN_K           = 3,
  parameter int ALTERNATE_START = 1
) (
  input  logic                         CLK_100MHZ,
  input  logic                         reset,
  input  logic [BOARD_N*BOARD_N-1:0]   cell_sel,
  input  logic                         click,
  input  logic                         any_click,
  input  logic                         erase,
  input  logic                         restart,
  output logic [BOARD_N*BOARD_N-1:0]   x_matrix,
  output logic [BOARD_N*BOARD_N-1:0]   o_matrix,
  output logic                         turn_x,
  output logic                         busy,
  output logic                         display_start,
  output logic                         display_win_x,
  output logic                         display_win_o,
  output logic                         display_tie,
  output logic                         inc_x_score,
  output logic                         inc_o_score,
  output logic [3:0]                   score_x_tens,
  output logic [3:0]                   score_x_units,
  output logic [3:0]                   score_o_tens,
  output logic [3:0]                   score_o_units
);

  localparam int CELLS = BOARD_N * BOARD_N;
  localparam int IW    = $clog2(CELLS);
  localparam int RW    = $clog2(BOARD_N);

  typedef enum logic [2:0] {S_START, S_PLAY, S_CHECK, S_WIN_X, S_WIN_O, S_TIE} state_t;

  state_t           state;
  logic             click_q, any_q, erase_q, restart_q;
  logic             ev_restart, ev_erase, ev_click, ev_any, raw_erase, raw_click;
  logic             start_x, undo_ok, last_x, win;
  logic [1:0]       dir;
  logic [CELLS-1:0] last_mask, mine;
  logic [RW-1:0]    last_row, last_col;
  logic             click_ok, fwd, bwd, hit;
  int               dr, dc, run_len, sel_row, sel_col;

  // {display_start, display_win_x, display_win_o, display_tie, busy}
  function automatic logic [4:0] screen(input state_t s);
    case (s)
      S_START: screen = 5'b10000;
      S_WIN_X: screen = 5'b01000;
      S_WIN_O: screen = 5'b00100;
      S_TIE:   screen = 5'b00010;
      S_CHECK: screen = 5'b00001;
      default: screen = 5'b00000;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic cell_at(input logic [CELLS-1:0] m, input int r, input int c);
    if (r < 0 || r >= BOARD_N || c < 0 || c >= BOARD_N) return 1'b0;
    return m[IW'(r * BOARD_N + c)];
  endfunction

  assign raw_erase  = erase & ~erase_q;
  assign raw_click  = click & ~click_q;
  assign ev_restart = restart & ~restart_q;
  assign ev_erase   = raw_erase & ~ev_restart;
  assign ev_click   = raw_click & ~ev_restart & ~raw_erase;
  assign ev_any     = any_click & ~any_q & ~ev_restart & ~raw_erase & ~raw_click;

  assign click_ok = $onehot(cell_sel) && ((cell_sel & (x_matrix | o_matrix)) == '0);

  always_comb begin
    sel_row = 0;
    sel_col = 0;
    for (int r = 0; r < BOARD_N; r++)
      for (int c = 0; c < BOARD_N; c++)
        if (cell_sel[IW'(r * BOARD_N + c)]) begin
          sel_row = r;
          sel_col = c;
        end
  end

  // Run length through the last placed cell along the current direction, both ways.
  always_comb begin
    case (dir)
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      2'd3:    begin dr = 1; dc = -1; end
      default: begin dr = 0; dc = 1;  end
    endcase
    mine    = turn_x ? x_matrix : o_matrix;
    run_len = 1;
    fwd     = 1'b1;
    bwd     = 1'b1;
    for (int k = 1; k < BOARD_N; k++) begin
      if (fwd && cell_at(mine, int'(last_row) + k * dr, int'(last_col) + k * dc))
        run_len = run_len + 1;
      else
        fwd = 1'b0;
      if (bwd && cell_at(mine, int'(last_row) - k * dr, int'(last_col) - k * dc))
        run_len = run_len + 1;
      else
        bwd = 1'b0;
    end
    hit = (run_len >= WIN_K);
  end

  always_ff @(posedge CLK_100MHZ or negedge reset) begin
    if (!reset) begin
      {click_q, any_q, erase_q, restart_q} <= 4'b0;
    end else begin
      {click_q, any_q, erase_q, restart_q} <= {click, any_click, erase, restart};
    end
  end

  always_ff @(posedge CLK_100MHZ or negedge reset) begin
    if (!reset) begin
      state       <= S_START;
      x_matrix    <= '0;
      o_matrix    <= '0;
      turn_x      <= 1'b1;
      start_x     <= 1'b1;
      undo_ok     <= 1'b0;
      last_x      <= 1'b1;
      last_mask   <= '0;
      last_row    <= '0;
      last_col    <= '0;
      dir         <= 2'd0;
      win         <= 1'b0;
      inc_x_score <= 1'b0;
      inc_o_score <= 1'b0;
      {display_start, display_win_x, display_win_o, display_tie, busy} <= 5'b10000;
    end else begin
      inc_x_score <= 1'b0;
      inc_o_score <= 1'b0;
      if (ev_restart) begin
        state    <= S_START;
        x_matrix <= '0;
        o_matrix <= '0;
        turn_x   <= 1'b1;
        start_x  <= 1'b1;
        undo_ok  <= 1'b0;
        {display_start, display_win_x, display_win_o, display_tie, busy} <= screen(S_START);
      end else begin
        case (state)
          S_START: if (ev_any) begin
            state <= S_PLAY;
            {display_start, display_win_x, display_win_o, display_tie, busy} <= screen(S_PLAY);
          end
          S_PLAY: begin
            if (ev_erase) begin
              if (undo_ok) begin
                x_matrix <= x_matrix & ~last_mask;
                o_matrix <= o_matrix & ~last_mask;
                turn_x   <= last_x;
                undo_ok  <= 1'b0;
              end
            end else if (ev_click && click_ok) begin
              if (turn_x) x_matrix <= x_matrix | cell_sel;
              else        o_matrix <= o_matrix | cell_sel;
              last_mask <= cell_sel;
              last_row  <= RW'(sel_row);
              last_col  <= RW'(sel_col);
              last_x    <= turn_x;
              undo_ok   <= 1'b1;
              dir       <= 2'd0;
              win       <= 1'b0;
              state     <= S_CHECK;
              {display_start, display_win_x, display_win_o, display_tie, busy} <= screen(S_CHECK);
            end
          end
          S_CHECK: begin
            dir <= dir + 2'd1;
            if (hit) win <= 1'b1;
            if (dir == 2'd3) begin
              if (win || hit) begin
                state       <= turn_x ? S_WIN_X : S_WIN_O;
                inc_x_score <= turn_x;
                inc_o_score <= ~turn_x;
                {display_start, display_win_x, display_win_o, display_tie, busy} <=
                  screen(turn_x ? S_WIN_X : S_WIN_O);
              end else if (&(x_matrix | o_matrix)) begin
                state <= S_TIE;
                {display_start, display_win_x, display_win_o, display_tie, busy} <= screen(S_TIE);
              end else begin
                turn_x <= ~turn_x;
                state  <= S_PLAY;
                {display_start, display_win_x, display_win_o, display_tie, busy} <= screen(S_PLAY);
              end
            end
          end
          S_WIN_X, S_WIN_O, S_TIE: if (ev_any) begin
            state    <= S_PLAY;
            x_matrix <= '0;
            o_matrix <= '0;
            undo_ok  <= 1'b0;
            start_x  <= (ALTERNATE_START != 0) ? ~start_x : 1'b1;
            turn_x   <= (ALTERNATE_START != 0) ? ~start_x : 1'b1;
            {display_start, display_win_x, display_win_o, display_tie, busy} <= screen(S_PLAY);
          end
          default: state <= S_START;
        endcase
      end
    end
  end

  // Scores follow the one-cycle inc pulses; restart wins over a coincident pulse.
  always_ff @(posedge CLK_100MHZ or negedge reset) begin
    if (!reset) begin
      {score_x_tens, score_x_units, score_o_tens, score_o_units} <= 16'h0000;
    end else if (ev_restart) begin
      {score_x_tens, score_x_units, score_o_tens, score_o_units} <= 16'h0000;
    end else begin
      if (inc_x_score) {score_x_tens, score_x_units} <= bcd_inc({score_x_tens, score_x_units});
      if (inc_o_score) {score_o_tens, score_o_units} <= bcd_inc({score_o_tens, score_o_units});
    end
  end

endmodule

// File: tb/tb_game_board_engine.sv
// Directed bench for game_board_engine: a 3x3/K=3 instance for game flow and a
// 5x5/K=4 instance for the longer anti-diagonal win.
module tb_game_board_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [8:0]  cell_sel;
  logic        click, any_click, erase, restart;
  logic [8:0]  x_matrix, o_matrix;
  logic        turn_x, busy, display_start, display_win_x, display_win_o, display_tie;
  logic        inc_x_score, inc_o_score;
  logic [3:0]  score_x_tens, score_x_units, score_o_tens, score_o_units;

  logic [24:0] cell_sel5;
  logic        click5, any_click5, erase5, restart5;
  logic [24:0] x_matrix5, o_matrix5;
  logic        turn_x5, busy5, ds5, dwx5, dwo5, dt5, incx5, inco5;
  logic [3:0]  sxt5, sxu5, sot5, sou5;

  logic [4:0]  flags, flags5;
  assign flags  = {display_start, display_win_x, display_win_o, display_tie, busy};
  assign flags5 = {ds5, dwx5, dwo5, dt5, busy5};

  int tests_run = 0, tests_failed = 0;
  int incx_cnt = 0, inco_cnt = 0, busy_cnt = 0;

  game_board_engine #(.BOARD_N(3), .WIN_K(3), .ALTERNATE_START(1)) dut (
    .CLK_100MHZ(clk), .reset(reset), .cell_sel(cell_sel), .click(click),
    .any_click(any_click), .erase(erase), .restart(restart),
    .x_matrix(x_matrix), .o_matrix(o_matrix), .turn_x(turn_x), .busy(busy),
    .display_start(display_start), .display_win_x(display_win_x),
    .display_win_o(display_win_o), .display_tie(display_tie),
    .inc_x_score(inc_x_score), .inc_o_score(inc_o_score),
    .score_x_tens(score_x_tens), .score_x_units(score_x_units),
    .score_o_tens(score_o_tens), .score_o_units(score_o_units));

  game_board_engine #(.BOARD_N(5), .WIN_K(4), .ALTERNATE_START(1)) dut5 (
    .CLK_100MHZ(clk), .reset(reset), .cell_sel(cell_sel5), .click(click5),
    .any_click(any_click5), .erase(erase5), .restart(restart5),
    .x_matrix(x_matrix5), .o_matrix(o_matrix5), .turn_x(turn_x5), .busy(busy5),
    .display_start(ds5), .display_win_x(dwx5), .display_win_o(dwo5), .display_tie(dt5),
    .inc_x_score(incx5), .inc_o_score(inco5),
    .score_x_tens(sxt5), .score_x_units(sxu5), .score_o_tens(sot5), .score_o_units(sou5));

  always @(negedge clk) begin
    if (inc_x_score) incx_cnt <= incx_cnt + 1;
    if (inc_o_score) inco_cnt <= inco_cnt + 1;
    if (busy)        busy_cnt <= busy_cnt + 1;
  end

  task automatic press_any();
    @(negedge clk) any_click = 1'b1;
    @(negedge clk) any_click = 1'b0;
  endtask

  task automatic press_erase();
    @(negedge clk) erase = 1'b1;
    @(negedge clk) erase = 1'b0;
  endtask

  // Returns 5 negedges after the click rose: the move is fully resolved.
  task automatic place(input int idx);
    @(negedge clk);
    cell_sel = 9'd1 << idx;
    click    = 1'b1;
    @(negedge clk) click = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic place5(input int idx);
    @(negedge clk);
    cell_sel5 = 25'd1 << idx;
    click5    = 1'b1;
    @(negedge clk) click5 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    {cell_sel, click, any_click, erase, restart} = '0;
    {cell_sel5, click5, any_click5, erase5, restart5} = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({x_matrix, o_matrix} !== 18'd0) begin
      tests_failed++; $display("FAIL reset_matrices: got %h expected 0", {x_matrix, o_matrix});
    end
    tests_run++;
    if ({flags, turn_x, inc_x_score, inc_o_score} !== 8'b10000_1_00) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 10000100", {flags, turn_x, inc_x_score, inc_o_score});
    end
    tests_run++;
    if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_scores: got %h expected 0000", {score_x_tens, score_x_units, score_o_tens, score_o_units});
    end
    tests_run++;
    if ({x_matrix5, o_matrix5, flags5} !== {50'd0, 5'b10000}) begin
      tests_failed++; $display("FAIL reset_5x5: got %h/%b expected 0/10000", {x_matrix5, o_matrix5}, flags5);
    end
    reset = 1'b1;
  endtask

  task automatic test_win_x();
    press_any();
    tests_run++;
    if ({flags, turn_x} !== 6'b00000_1) begin
      tests_failed++; $display("FAIL start_to_play: got %b expected 000001", {flags, turn_x});
    end
    place(0);
    tests_run++;
    if ({x_matrix, turn_x} !== {9'b000000001, 1'b0}) begin
      tests_failed++; $display("FAIL first_move: got %h/%b expected 001/0", x_matrix, turn_x);
    end
    place(3); place(1); place(4);
    tests_run++;
    if ({x_matrix, o_matrix, turn_x} !== {9'b000000011, 9'b000011000, 1'b1}) begin
      tests_failed++; $display("FAIL pre_win_board: got %h/%h/%b expected 003/018/1", x_matrix, o_matrix, turn_x);
    end
    @(negedge clk);
    cell_sel = 9'd1 << 2;
    click    = 1'b1;
    @(negedge clk) click = 1'b0;
    tests_run++;
    if (flags !== 5'b00001) begin
      tests_failed++; $display("FAIL check_busy_start: got %b expected 00001", flags);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (flags !== 5'b00001) begin
      tests_failed++; $display("FAIL check_busy_end: got %b expected 00001", flags);
    end
    @(negedge clk);
    tests_run++;
    if ({flags, inc_x_score, score_x_units} !== {5'b01000, 1'b1, 4'd0}) begin
      tests_failed++; $display("FAIL win_x_entry: got %b/%b/%h expected 01000/1/0", flags, inc_x_score, score_x_units);
    end
    @(negedge clk);
    tests_run++;
    if ({inc_x_score, score_x_tens, score_x_units, x_matrix} !== {1'b0, 8'h01, 9'b000000111}) begin
      tests_failed++; $display("FAIL win_x_score: got %b/%h/%h expected 0/01/007", inc_x_score, {score_x_tens, score_x_units}, x_matrix);
    end
    #1;
    tests_run++;
    if (incx_cnt !== 1) begin
      tests_failed++; $display("FAIL inc_x_width: got %0d expected 1", incx_cnt);
    end
  endtask

  task automatic test_invalid();
    int b0;
    press_any();
    tests_run++;
    if ({x_matrix, o_matrix, turn_x, flags} !== {18'd0, 1'b0, 5'b00000}) begin
      tests_failed++; $display("FAIL new_game_o_starts: got %h/%b/%b expected 0/0/00000", {x_matrix, o_matrix}, turn_x, flags);
    end
    place(4);
    #1 b0 = busy_cnt;
    place(4);
    tests_run++;
    if ({x_matrix, o_matrix, turn_x, flags} !== {9'd0, 9'h010, 1'b1, 5'b00000}) begin
      tests_failed++; $display("FAIL occupied_click: got %h/%h/%b/%b expected 000/010/1/00000", x_matrix, o_matrix, turn_x, flags);
    end
    @(negedge clk);
    cell_sel = 9'b000000011;
    click    = 1'b1;
    @(negedge clk) click = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if ({x_matrix, o_matrix, turn_x, flags} !== {9'd0, 9'h010, 1'b1, 5'b00000}) begin
      tests_failed++; $display("FAIL multi_hot_click: got %h/%h/%b/%b expected 000/010/1/00000", x_matrix, o_matrix, turn_x, flags);
    end
    tests_run++;
    if (busy_cnt !== b0) begin
      tests_failed++; $display("FAIL invalid_busy: got %0d busy cycles expected 0", busy_cnt - b0);
    end
  endtask

  task automatic test_undo();
    place(0);
    tests_run++;
    if ({x_matrix, turn_x} !== {9'h001, 1'b0}) begin
      tests_failed++; $display("FAIL undo_setup: got %h/%b expected 001/0", x_matrix, turn_x);
    end
    press_erase();
    tests_run++;
    if ({x_matrix, o_matrix, turn_x} !== {9'd0, 9'h010, 1'b1}) begin
      tests_failed++; $display("FAIL undo: got %h/%h/%b expected 000/010/1", x_matrix, o_matrix, turn_x);
    end
    press_erase();
    tests_run++;
    if ({x_matrix, o_matrix, turn_x} !== {9'd0, 9'h010, 1'b1}) begin
      tests_failed++; $display("FAIL second_undo: got %h/%h/%b expected 000/010/1", x_matrix, o_matrix, turn_x);
    end
    place(0);
    @(negedge clk);
    cell_sel = 9'd1 << 1;
    click    = 1'b1;
    erase    = 1'b1;
    @(negedge clk);
    click = 1'b0;
    erase = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if ({x_matrix, o_matrix, turn_x, flags} !== {9'd0, 9'h010, 1'b1, 5'b00000}) begin
      tests_failed++; $display("FAIL erase_beats_click: got %h/%h/%b/%b expected 000/010/1/00000", x_matrix, o_matrix, turn_x, flags);
    end
  endtask

  task automatic test_restart_mid_check();
    int c0;
    place(0); place(3); place(1); place(8);
    tests_run++;
    if ({x_matrix, o_matrix, turn_x} !== {9'h003, 9'h118, 1'b1}) begin
      tests_failed++; $display("FAIL restart_setup: got %h/%h/%b expected 003/118/1", x_matrix, o_matrix, turn_x);
    end
    #1 c0 = incx_cnt;
    @(negedge clk);
    cell_sel = 9'd1 << 2;
    click    = 1'b1;
    @(negedge clk) click = 1'b0;
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    tests_run++;
    if ({flags, turn_x, x_matrix, o_matrix} !== {5'b10000, 1'b1, 18'd0}) begin
      tests_failed++; $display("FAIL restart_state: got %b/%b/%h expected 10000/1/0", flags, turn_x, {x_matrix, o_matrix});
    end
    tests_run++;
    if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0000) begin
      tests_failed++; $display("FAIL restart_scores: got %h expected 0000", {score_x_tens, score_x_units, score_o_tens, score_o_units});
    end
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if ({incx_cnt - c0, flags} !== {32'd0, 5'b10000}) begin
      tests_failed++; $display("FAIL restart_no_pulse: got %0d pulses/%b expected 0/10000", incx_cnt - c0, flags);
    end
  endtask

  task automatic test_tie();
    int cx, co;
    press_any();
    tests_run++;
    if (turn_x !== 1'b1) begin
      tests_failed++; $display("FAIL after_restart_turn: got %b expected 1", turn_x);
    end
    #1 begin cx = incx_cnt; co = inco_cnt; end
    place(0); place(1); place(2); place(4); place(3);
    place(5); place(7); place(6); place(8);
    #1;
    tests_run++;
    if ({flags, x_matrix, o_matrix} !== {5'b00010, 9'b110001101, 9'b001110010}) begin
      tests_failed++; $display("FAIL tie: got %b/%h/%h expected 00010/18d/072", flags, x_matrix, o_matrix);
    end
    tests_run++;
    if ({incx_cnt - cx, inco_cnt - co} !== 64'd0) begin
      tests_failed++; $display("FAIL tie_no_pulse: got %0d/%0d expected 0/0", incx_cnt - cx, inco_cnt - co);
    end
    tests_run++;
    if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0000) begin
      tests_failed++; $display("FAIL tie_scores: got %h expected 0000", {score_x_tens, score_x_units, score_o_tens, score_o_units});
    end
  endtask

  task automatic test_win_o();
    press_any();
    tests_run++;
    if (turn_x !== 1'b0) begin
      tests_failed++; $display("FAIL alternate_start: got %b expected 0", turn_x);
    end
    place(3); place(0); place(4); place(1); place(5);
    tests_run++;
    if ({flags, inc_o_score} !== {5'b00100, 1'b1}) begin
      tests_failed++; $display("FAIL win_o: got %b/%b expected 00100/1", flags, inc_o_score);
    end
    @(negedge clk);
    tests_run++;
    if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0001) begin
      tests_failed++; $display("FAIL win_o_score: got %h expected 0001", {score_x_tens, score_x_units, score_o_tens, score_o_units});
    end
  endtask

  task automatic x_win_game();
    press_any();
    if (turn_x) begin
      place(0); place(3); place(1); place(4); place(2);
    end else begin
      place(3); place(0); place(4); place(1); place(8); place(2);
    end
    @(negedge clk);
  endtask

  task automatic test_score_wrap();
    for (int i = 1; i <= 100; i++) begin
      x_win_game();
      if (i == 10) begin
        tests_run++;
        if ({score_x_tens, score_x_units} !== 8'h10) begin
          tests_failed++; $display("FAIL score_carry: got %h expected 10", {score_x_tens, score_x_units});
        end
      end else if (i == 99) begin
        tests_run++;
        if ({score_x_tens, score_x_units} !== 8'h99) begin
          tests_failed++; $display("FAIL score_99: got %h expected 99", {score_x_tens, score_x_units});
        end
      end else if (i == 100) begin
        tests_run++;
        if ({score_x_tens, score_x_units, score_o_tens, score_o_units, display_win_x} !== {16'h0001, 1'b1}) begin
          tests_failed++; $display("FAIL score_wrap: got %h/%b expected 0001/1", {score_x_tens, score_x_units, score_o_tens, score_o_units}, display_win_x);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    press_any();
    place(0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({x_matrix, o_matrix, flags, turn_x} !== {18'd0, 5'b10000, 1'b1}) begin
      tests_failed++; $display("FAIL async_reset_state: got %h/%b/%b expected 0/10000/1", {x_matrix, o_matrix}, flags, turn_x);
    end
    tests_run++;
    if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0000) begin
      tests_failed++; $display("FAIL async_reset_scores: got %h expected 0000", {score_x_tens, score_x_units, score_o_tens, score_o_units});
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_5x5_anti_diag();
    @(negedge clk) any_click5 = 1'b1;
    @(negedge clk) any_click5 = 1'b0;
    place5(4); place5(0); place5(8); place5(1); place5(12);
    tests_run++;
    if ({flags5, turn_x5} !== {5'b00000, 1'b0}) begin
      tests_failed++; $display("FAIL k4_three_long: got %b/%b expected 00000/0", flags5, turn_x5);
    end
    place5(2);
    tests_run++;
    if ({flags5, turn_x5} !== {5'b00000, 1'b1}) begin
      tests_failed++; $display("FAIL k4_three_row_o: got %b/%b expected 00000/1", flags5, turn_x5);
    end
    place5(16);
    tests_run++;
    if ({flags5, incx5, x_matrix5, o_matrix5} !== {5'b01000, 1'b1, 25'h0011110, 25'h0000007}) begin
      tests_failed++; $display("FAIL k4_anti_diag_win: got %b/%b/%h/%h expected 01000/1/0011110/0000007", flags5, incx5, x_matrix5, o_matrix5);
    end
  endtask

  initial begin
    test_reset();
    test_win_x();
    test_invalid();
    test_undo();
    test_restart_mid_check();
    test_tie();
    test_win_o();
    test_score_wrap();
    test_async_reset();
    test_5x5_anti_diag();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
